// File: rtl/iter_unit_arb.sv
// Two-requester round-robin arbiter sequencing a multi-step iterative datapath (optional ITER_UNIT_EARLY_DONE_EN).
// Latency: accept edge, STEP_NUM RUN cycles, then rsp_valid; req_ready is combinational from req_valid/flush.
// Backpressure: rsp_valid holds in DONE until rsp_ready; no new grant until the response handshake completes.
module iter_unit_arb #(
    parameter int STEP_NUM   = 40,
    parameter int STEP_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic                  flush,
    output logic                  dp_start,
    output logic                  dp_step_en,
    output logic [STEP_WIDTH-1:0] dp_step_cnt,
    output logic                  dp_owner,
    output logic                  rsp_valid,
    input  logic                  rsp_ready
`ifdef ITER_UNIT_EARLY_DONE_EN
    ,
    input  logic                  dp_early_done
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(STEP_NUM - 1);

    state_t                state, state_nxt;
    logic [STEP_WIDTH-1:0] cnt, cnt_nxt;
    logic                  owner, owner_nxt;
    logic                  last_owner, last_owner_nxt;
    logic [1:0]            grant;
    logic                  early_done;

`ifdef ITER_UNIT_EARLY_DONE_EN
    assign early_done = dp_early_done;
`else
    assign early_done = 1'b0;
`endif

    // On a tie the requester that did not finish last wins.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_owner ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign req_ready = (state == IDLE && !flush && reset) ? grant : 2'b00;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_ready) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                        owner_nxt = req_ready[1];
                    end
                end
                RUN: begin
                    if (cnt == LAST_STEP || early_done) begin
                        state_nxt = DONE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state_nxt      = IDLE;
                        last_owner_nxt = owner;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    assign dp_step_en  = (state == RUN);
    assign dp_start    = (state == RUN) && (cnt == '0);
    assign rsp_valid   = (state == DONE);
    assign dp_step_cnt = cnt;
    assign dp_owner    = owner;

endmodule

// File: doc/iter_unit_arb.md
ITER_UNIT_ARB -- requirements
Module: iter_unit_arb

Interface
REQ-001 Parameter STEP_NUM, default 40, number of datapath steps per operation (32 data + 8 overhead); legal range 2..63.
REQ-002 Parameter STEP_WIDTH, default 6, width of the step count; SHALL satisfy 2^STEP_WIDTH >= STEP_NUM.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  2  per-requester operation request (bit 0 = requester 0, bit 1 = requester 1).
REQ-006 req_ready  output  2  per-requester accept; at most one bit high in any cycle.
REQ-007 flush  input  1  abort the current operation and discard any pending response.
REQ-008 dp_start  output  1  one-cycle pulse in the first RUN cycle; the datapath loads operands.
REQ-009 dp_step_en  output  1  datapath advances one step this cycle.
REQ-010 dp_step_cnt  output  STEP_WIDTH  current step index, 0..STEP_NUM-1.
REQ-011 dp_owner  output  1  requester index owning the datapath; held for the operation's lifetime.
REQ-012 rsp_valid  output  1  result available for requester dp_owner.
REQ-013 rsp_ready  input  1  response consumer accept.

Function
REQ-014 FSM states: IDLE, RUN, DONE; state, step count, owner and round-robin pointer are registers.
REQ-015 IDLE: req_ready = grant one-hot, gated by !flush; grant = the requester with valid set; if both are set, grant the one not equal to last_owner.
REQ-016 Accept (req_valid[i] & req_ready[i]) -> next state RUN, dp_owner <= i, dp_step_cnt <= 0.
REQ-017 RUN: dp_step_en = 1; dp_start = (dp_step_cnt == 0); dp_step_cnt increments by 1 per cycle.
REQ-018 RUN with dp_step_cnt == STEP_NUM-1 -> next state DONE, dp_step_cnt <= 0 (wrap; no overflow past STEP_NUM-1).
REQ-019 Latency: accept edge E, then RUN for exactly STEP_NUM cycles; rsp_valid is first high in the cycle after edge E+STEP_NUM.
REQ-020 DONE: rsp_valid = 1, dp_step_en = 0, dp_start = 0; rsp_valid holds until rsp_ready; rsp_valid & rsp_ready -> IDLE, last_owner <= dp_owner.
REQ-021 No back-to-back overlap: req_ready = 0 in RUN and DONE; a new grant is first possible in the cycle after the DONE handshake.
REQ-022 flush in any state -> IDLE at the next edge, dp_step_cnt <= 0, last_owner unchanged, no rsp_valid issued.
REQ-023 flush has priority over accept, step increment and the response handshake in the same cycle.
REQ-024 req_valid deasserting while RUN/DONE does not affect the operation.
REQ-025 dp_step_cnt, dp_step_en, dp_start and rsp_valid are outputs decoded from registered state only; there is no combinational path from inputs to these outputs. req_ready alone depends combinationally on req_valid and flush.

Reset
REQ-026 reset low -> state IDLE, dp_step_cnt 0, dp_owner 0, last_owner 1 (so requester 0 wins first tie), immediately and asynchronously.
REQ-027 During reset: req_ready 0, dp_start 0, dp_step_en 0, rsp_valid 0; reset mid-RUN drops the operation with no response.

Configuration
REQ-028 Macro ITER_UNIT_EARLY_DONE_EN, when defined, adds input dp_early_done (1 bit): in RUN, dp_early_done = 1 -> DONE at the next edge regardless of dp_step_cnt, dp_step_cnt <= 0; flush still takes priority.
REQ-029 Without ITER_UNIT_EARLY_DONE_EN, the port is absent and every operation takes exactly STEP_NUM RUN cycles.

Verification
REQ-030 Single req_valid=01 at cycle 0, rsp_ready=1 -> req_ready=01 at cycle 0; dp_start at cycle 1 only; dp_step_cnt 0..39 over cycles 1..40; rsp_valid=1, dp_owner=0 at cycle 41; IDLE at cycle 42.
REQ-031 req_valid=11 held over three operations -> grants 0,1,0; each grant is one-hot; req_ready=00 between grants.
REQ-032 rsp_ready=0 for 5 cycles in DONE -> rsp_valid stays 1, dp_step_en=0, req_ready=00; the handshake on the 6th cycle returns the FSM to IDLE.
REQ-033 flush at dp_step_cnt=17 -> IDLE next cycle, no rsp_valid ever; flush coincident with req_valid=01 in IDLE -> req_ready=00 and no operation.
REQ-034 reset asserted at dp_step_cnt=20 -> all outputs 0 asynchronously; after release, operation from REQ-030 repeats with identical timing.
REQ-035 With ITER_UNIT_EARLY_DONE_EN: dp_early_done at dp_step_cnt=3 -> rsp_valid next cycle; without it, dp_early_done is absent and the latency is 40 cycles.
